// File: rtl/zeroriscy_trace_ctrl_pkg.sv
// Shared types and constants for the zero-riscy trace capture controller.
// Holds the FSM state encoding, the record layout and the record-to-word mapping.
package zeroriscy_trace_pkg;

  localparam int unsigned REC_WORDS = 4;
  localparam int unsigned TSTAMP_W  = 26;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic                rd_we;
    logic [4:0]          rd_addr;
    logic [TSTAMP_W-1:0] tstamp;
    logic [31:0]         pc;
    logic [31:0]         instr;
    logic [31:0]         wdata;
  } trace_rec_t;

  // Word order on the stream: header, pc, instr, write data (zero when no write).
  function automatic logic [31:0] rec_word(input trace_rec_t rec, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = {rec.rd_we, rec.rd_addr, rec.tstamp};
      2'd1:    w = rec.pc;
      2'd2:    w = rec.instr;
      default: w = rec.rd_we ? rec.wdata : '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/zeroriscy_trace_ctrl_if.sv
// Valid/ready word stream carrying serialized trace records to the debug/host side.
// master drives the words, slave supplies backpressure.
interface zeroriscy_trace_ctrl_if;
  logic        rec_valid;
  logic        rec_ready;
  logic [31:0] rec_data;
  logic        rec_last;

  modport master (output rec_valid, output rec_data, output rec_last, input rec_ready);
  modport slave  (input rec_valid, input rec_data, input rec_last, output rec_ready);
endinterface

// File: rtl/zeroriscy_trace_fifo.sv
// Single-clock first-word-fall-through FIFO of trace records.
// A push while full is still accepted when a pop happens in the same cycle.
module zeroriscy_trace_fifo
  import zeroriscy_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  trace_rec_t             i_wdata,
  output trace_rec_t             o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  trace_rec_t    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/zeroriscy_trace_ctrl.sv
// Trace capture controller: PC-triggered arm/capture/stop FSM, record FIFO and 4-word serializer.
// Define TRACE_CTRL_TSTAMP_EN to build the 26-bit cycle timestamp; otherwise w0[25:0] is zero.
module zeroriscy_trace_ctrl
  import zeroriscy_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arm,
  input  logic                          stop,
  input  logic                          cfg_start_any,
  input  logic [31:0]                   cfg_start_pc,
  input  logic [31:0]                   cfg_stop_pc,
  input  logic                          ret_valid,
  input  logic [31:0]                   ret_pc,
  input  logic [31:0]                   ret_instr,
  input  logic                          ret_rd_we,
  input  logic [4:0]                    ret_rd_addr,
  input  logic [31:0]                   ret_rd_wdata,
  zeroriscy_trace_ctrl_if.master        rec,
  output logic [1:0]                    state,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]        fifo_cnt
);
  trace_state_e        r_state;
  trace_state_e        w_state_nxt;
  logic                w_push_req;
  logic                w_clear;
  logic                w_start_hit;
  logic                w_stop_hit;
  logic [TSTAMP_W-1:0] w_tstamp;
  trace_rec_t          w_rec;
  trace_rec_t          w_head;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_accept;
  logic                w_load;
  logic                w_drop;

  trace_rec_t          r_rec;
  logic [1:0]          r_idx;
  logic                r_valid;
  logic                r_last;
  logic [31:0]         r_data;
  logic                r_overflow;
  logic [CNT_W-1:0]    r_drop_cnt;

`ifdef TRACE_CTRL_TSTAMP_EN
  logic [TSTAMP_W-1:0] r_tstamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tstamp <= '0;
    else        r_tstamp <= r_tstamp + TSTAMP_W'(1);
  end

  assign w_tstamp = r_tstamp;
`else
  assign w_tstamp = '0;
`endif

  assign w_start_hit = ret_valid & (cfg_start_any | (ret_pc == cfg_start_pc));
  assign w_stop_hit  = ret_valid & (ret_pc == cfg_stop_pc);

  assign w_rec = '{rd_we:   ret_rd_we,
                   rd_addr: ret_rd_addr,
                   tstamp:  w_tstamp,
                   pc:      ret_pc,
                   instr:   ret_instr,
                   wdata:   ret_rd_wdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (arm) begin
          w_state_nxt = ARMED;
          w_clear     = 1'b1;
        end
      end
      ARMED: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (w_start_hit) begin
          w_push_req  = 1'b1;
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        w_push_req = ret_valid;
        if (stop || w_stop_hit) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_fifo_empty && !r_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reloading on acceptance of w3 keeps records back to back and frees a FIFO slot for a same-cycle push.
  assign w_accept = r_valid & rec.rec_ready;
  assign w_load   = ~w_fifo_empty & (~r_valid | (w_accept & r_last));
  assign w_drop   = w_push_req & w_fifo_full & ~w_load;

  zeroriscy_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_req),
    .i_pop   (w_load),
    .i_wdata (w_rec),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rec   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_rec   <= w_head;
      r_idx   <= 2'd1;
      r_valid <= 1'b1;
      r_last  <= 1'b0;
      r_data  <= rec_word(w_head, 2'd0);
    end else if (w_accept) begin
      if (r_last) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_data  <= '0;
      end else begin
        r_data  <= rec_word(r_rec, r_idx);
        r_last  <= (r_idx == 2'(REC_WORDS - 1));
        r_idx   <= r_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_clear) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign rec.rec_valid = r_valid;
  assign rec.rec_data  = r_data;
  assign rec.rec_last  = r_last;
  assign state         = r_state;
  assign overflow      = r_overflow;
  assign drop_cnt      = r_drop_cnt;

endmodule
